// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the memory arbiter:
//   fetch side  : i_valid, i_addr            -> arbiter
//                 i_data_ok, i_data          <- arbiter
//   data side   : d_valid, d_addr, d_size,
//                 d_strobe, d_wdata          -> arbiter
//                 d_data_ok, d_rdata         <- arbiter
//   memory side : m_valid, m_addr, m_size,
//                 m_strobe, m_wdata          <- arbiter
//                 m_data_ok, m_rdata         -> arbiter
// Modport slave is the arbiter's view; master is the surrounding system
// (pipeline requesters plus downstream memory).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 64
);
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_data_ok;
    logic [31:0]   i_data;

    logic          d_valid;
    logic [AW-1:0] d_addr;
    logic [2:0]    d_size;
    logic [7:0]    d_strobe;
    logic [63:0]   d_wdata;
    logic          d_data_ok;
    logic [63:0]   d_rdata;

    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_size;
    logic [7:0]    m_strobe;
    logic [63:0]   m_wdata;
    logic          m_data_ok;
    logic [63:0]   m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_data_ok, d_rdata,
        output m_valid, m_addr, m_size, m_strobe, m_wdata,
        input  m_data_ok, m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_data_ok, d_rdata,
        input  m_valid, m_addr, m_size, m_strobe, m_wdata,
        output m_data_ok, m_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one downstream memory port between instruction fetch and
// load/store. Data requests win by default; a streak counter forces a
// waiting fetch through after MAX_D_STREAK consecutive data grants.
// Responses are steered combinationally to the owner of the in-flight
// transaction in the same cycle as m_data_ok.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - synchronous active-low reset
//   bus    - mem_arbiter_if.slave (fetch, data and memory buses)
// Parameters:
//   MAX_D_STREAK - data grants tolerated while a fetch waits (1..15)
//   AW           - address width
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int AW           = 64
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [1:0]    r_state;
    logic [3:0]    r_streak;
    logic          r_sel_hi;
    logic          r_m_valid;
    logic [AW-1:0] r_m_addr;
    logic [2:0]    r_m_size;
    logic [7:0]    r_m_strobe;
    logic [63:0]   r_m_wdata;

    logic          w_done;
    logic          w_decide;
    logic          w_cand_i;
    logic          w_cand_d;
    logic          w_grant_i;
    logic          w_grant_d;
    logic [3:0]    w_streak_next;
    logic [31:0]   w_i_data;

    // A busy state only re-arbitrates on its completion cycle. The owner's
    // valid still shows the request being retired, so it is not a candidate.
    assign w_done    = (r_state != ST_IDLE) && bus.m_data_ok;
    assign w_decide  = (r_state == ST_IDLE) || w_done;
    assign w_cand_i  = bus.i_valid && (r_state != ST_BUSY_I);
    assign w_cand_d  = bus.d_valid && (r_state != ST_BUSY_D);

    assign w_grant_i = w_decide && w_cand_i &&
                       (!w_cand_d || (r_streak == STREAK_MAX));
    assign w_grant_d = w_decide && w_cand_d && !w_grant_i;

    // The streak only grows while a fetch is pending; a data grant with no
    // fetch pending means nobody is being starved, so it restarts.
    always_comb begin
        w_streak_next = r_streak;
        if (w_grant_i) begin
            w_streak_next = 4'd0;
        end else if (w_grant_d) begin
            if (!bus.i_valid) begin
                w_streak_next = 4'd0;
            end else if (r_streak < STREAK_MAX) begin
                w_streak_next = r_streak + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_streak   <= 4'd0;
            r_sel_hi   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_addr   <= '0;
            r_m_size   <= 3'd0;
            r_m_strobe <= 8'd0;
            r_m_wdata  <= 64'd0;
        end else begin
            r_streak <= w_streak_next;
            if (w_grant_i) begin
                r_state    <= ST_BUSY_I;
                r_m_valid  <= 1'b1;
                r_m_addr   <= bus.i_addr;
                r_m_size   <= 3'b010;
                r_m_strobe <= 8'd0;
                r_m_wdata  <= 64'd0;
                r_sel_hi   <= bus.i_addr[2];
            end else if (w_grant_d) begin
                r_state    <= ST_BUSY_D;
                r_m_valid  <= 1'b1;
                r_m_addr   <= bus.d_addr;
                r_m_size   <= bus.d_size;
                r_m_strobe <= bus.d_strobe;
                r_m_wdata  <= bus.d_wdata;
            end else if (w_done) begin
                r_state   <= ST_IDLE;
                r_m_valid <= 1'b0;
            end
        end
    end

    // Fetch word selection: the 32-bit instruction comes from the half of
    // the 64-bit beat picked by address bit 2 captured at grant time.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ilane
        assign w_i_data[gi*8 +: 8] = r_sel_hi ? bus.m_rdata[32 + gi*8 +: 8]
                                              : bus.m_rdata[gi*8 +: 8];
    end

    // Strobes are gated by the requester's current valid so a flushed
    // request completes downstream silently.
    assign bus.i_data_ok = (r_state == ST_BUSY_I) && bus.m_data_ok && bus.i_valid;
    assign bus.i_data    = w_i_data;
    assign bus.d_data_ok = (r_state == ST_BUSY_D) && bus.m_data_ok && bus.d_valid;
    assign bus.d_rdata   = bus.m_rdata;

    assign bus.m_valid   = r_m_valid;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_size    = r_m_size;
    assign bus.m_strobe  = r_m_strobe;
    assign bus.m_wdata   = r_m_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by a randomized phase. A behavioural model of
// the arbitration rules (owner, streak count, latched request) predicts the
// strobes, steered data and downstream request every cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int MAXS = 4;

    logic clk;
    logic reset;

    mem_arbiter_if #(.AW(64)) bus ();

    mem_arbiter #(.MAX_D_STREAK(MAXS), .AW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = nobody owns the port, 1 = fetch, 2 = data.
    int          md_own;
    int          md_streak;
    logic        e_mv;
    logic [63:0] e_addr;
    logic [2:0]  e_size;
    logic [7:0]  e_strb;
    logic [63:0] e_wd;
    logic        e_sel;
    logic        e_iok;
    logic        e_dok;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance the model with the
    // inputs as they stand, then check the registered outputs after the edge.
    task automatic step();
        logic [63:0] rd;
        logic        ci;
        logic        cd;
        logic        decide;
        #1;
        rd    = bus.m_rdata;
        e_iok = (md_own == 1) && bus.m_data_ok && bus.i_valid;
        e_dok = (md_own == 2) && bus.m_data_ok && bus.d_valid;
        check("i_data_ok", 64'(bus.i_data_ok), 64'(e_iok));
        check("d_data_ok", 64'(bus.d_data_ok), 64'(e_dok));
        if (e_iok) check("i_data", 64'(bus.i_data), e_sel ? 64'(rd[63:32]) : 64'(rd[31:0]));
        if (e_dok) check("d_rdata", bus.d_rdata, rd);

        if (!reset) begin
            md_own = 0; md_streak = 0; e_mv = 0; e_addr = 0;
            e_size = 0; e_strb = 0; e_wd = 0; e_sel = 0;
        end else begin
            decide = (md_own == 0) || bus.m_data_ok;
            ci = bus.i_valid && (md_own != 1);
            cd = bus.d_valid && (md_own != 2);
            if (decide && ci && (!cd || md_streak == MAXS)) begin
                md_own = 1; e_mv = 1; e_addr = bus.i_addr; e_size = 3'd2;
                e_strb = 0; e_wd = 0; e_sel = bus.i_addr[2]; md_streak = 0;
            end else if (decide && cd) begin
                md_own = 2; e_mv = 1; e_addr = bus.d_addr; e_size = bus.d_size;
                e_strb = bus.d_strobe; e_wd = bus.d_wdata;
                if (bus.i_valid) md_streak = (md_streak + 1 > MAXS) ? MAXS : md_streak + 1;
                else             md_streak = 0;
            end else if (md_own != 0 && bus.m_data_ok) begin
                md_own = 0; e_mv = 0;
            end
        end

        @(posedge clk);
        #1;
        check("m_valid",  64'(bus.m_valid),  64'(e_mv));
        check("m_addr",   bus.m_addr,        e_addr);
        check("m_size",   64'(bus.m_size),   64'(e_size));
        check("m_strobe", 64'(bus.m_strobe), 64'(e_strb));
        check("m_wdata",  bus.m_wdata,       e_wd);
        check("streak",   64'(dut.r_streak), 64'(md_streak));
    endtask

    initial begin
        reset = 1'b0;
        bus.i_valid = 0; bus.i_addr = 0;
        bus.d_valid = 0; bus.d_addr = 0; bus.d_size = 0; bus.d_strobe = 0; bus.d_wdata = 0;
        bus.m_data_ok = 0; bus.m_rdata = 0;
        md_own = 0; md_streak = 0; e_mv = 0; e_addr = 0; e_size = 0;
        e_strb = 0; e_wd = 0; e_sel = 0; e_iok = 0; e_dok = 0;

        @(posedge clk);
        #1;
        // Reset state
        step();
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_addr",  bus.m_addr,       64'd0);
        check("rst_streak",  64'(dut.r_streak), 64'd0);
        reset = 1'b1;

        // Single fetch, upper word selected by addr[2]
        bus.i_valid = 1; bus.i_addr = 64'h8000_0004;
        step();
        check("fetch_m_valid", 64'(bus.m_valid), 64'd1);
        check("fetch_m_addr",  bus.m_addr,       64'h8000_0004);
        check("fetch_m_size",  64'(bus.m_size),  64'd2);
        step();
        bus.m_data_ok = 1; bus.m_rdata = 64'h1111_2222_3333_4444;
        #1;
        check("fetch_i_data_ok", 64'(bus.i_data_ok), 64'd1);
        check("fetch_i_data",    64'(bus.i_data),    64'h1111_2222);
        step();
        check("fetch_back_idle", 64'(bus.m_valid), 64'd0);
        bus.m_data_ok = 0; bus.i_valid = 0;
        step();

        // Contention: data first, fetch follows with no bubble
        bus.i_valid = 1; bus.i_addr = 64'h2000;
        bus.d_valid = 1; bus.d_addr = 64'h100; bus.d_strobe = 8'hFF;
        bus.d_size = 3'd3; bus.d_wdata = 64'hDEAD_BEEF_0123_4567;
        step();
        check("cont_first_d_addr",   bus.m_addr,        64'h100);
        check("cont_first_d_strobe", 64'(bus.m_strobe), 64'hFF);
        bus.m_data_ok = 1; bus.m_rdata = 64'h55;
        #1;
        check("cont_d_ok", 64'(bus.d_data_ok), 64'd1);
        step();
        check("cont_switch_addr",  bus.m_addr,       64'h2000);
        check("cont_switch_valid", 64'(bus.m_valid), 64'd1);
        bus.m_data_ok = 0; bus.d_valid = 0; bus.d_strobe = 0;
        step();
        bus.m_data_ok = 1; bus.m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check("cont_i_data_lo", 64'(bus.i_data), 64'hCCCC_DDDD);
        step();
        bus.m_data_ok = 0; bus.i_valid = 0;
        step();

        // Starvation guard: fetch pending at four data grants in a row
        bus.i_addr = 64'h4004;
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1; bus.d_valid = 1; bus.d_strobe = 0;
            bus.d_addr = 64'h200 + 64'(k) * 64'd8;
            step();
            check("starve_d_grant", bus.m_addr, 64'h200 + 64'(k) * 64'd8);
            bus.m_data_ok = 1; bus.i_valid = 0;
            step();
            bus.m_data_ok = 0; bus.d_valid = 0;
        end
        check("starve_streak_sat", 64'(dut.r_streak), 64'd4);
        bus.i_valid = 1; bus.d_valid = 1; bus.d_addr = 64'h300;
        step();
        check("starve_fetch_forced", bus.m_addr,        64'h4004);
        check("starve_streak_clr",   64'(dut.r_streak), 64'd0);
        bus.m_data_ok = 1; bus.m_rdata = 64'h9999_8888_7777_6666;
        #1;
        check("starve_i_data_hi", 64'(bus.i_data), 64'h9999_8888);
        step();
        check("starve_then_d", bus.m_addr, 64'h300);
        bus.m_data_ok = 0; bus.i_valid = 0;
        step();
        bus.m_data_ok = 1;
        step();
        bus.m_data_ok = 0; bus.d_valid = 0;
        step();

        // Abort: owner drops valid, transaction drains silently
        bus.d_valid = 1; bus.d_addr = 64'h500; bus.d_strobe = 0;
        step();
        check("abort_granted", bus.m_addr, 64'h500);
        bus.d_valid = 0;
        step();
        step();
        bus.m_data_ok = 1;
        #1;
        check("abort_no_d_ok", 64'(bus.d_data_ok), 64'd0);
        step();
        check("abort_idle", 64'(bus.m_valid), 64'd0);
        bus.m_data_ok = 0;

        // Reset in the middle of a data transaction
        bus.d_valid = 1; bus.d_addr = 64'h600; bus.d_strobe = 8'h0F; bus.d_wdata = 64'h1234;
        step();
        check("midrst_busy", 64'(bus.m_valid), 64'd1);
        reset = 1'b0;
        step();
        check("midrst_m_valid",  64'(bus.m_valid),  64'd0);
        check("midrst_m_addr",   bus.m_addr,        64'd0);
        check("midrst_m_strobe", 64'(bus.m_strobe), 64'd0);
        check("midrst_m_wdata",  bus.m_wdata,       64'd0);
        reset = 1'b1; bus.d_valid = 0; bus.d_strobe = 0; bus.m_data_ok = 1;
        #1;
        check("midrst_stray_d_ok", 64'(bus.d_data_ok), 64'd0);
        check("midrst_stray_i_ok", 64'(bus.i_data_ok), 64'd0);
        step();
        check("idle_noise_m_valid", 64'(bus.m_valid), 64'd0);
        bus.m_data_ok = 0;
        step();

        // Randomized traffic with flushes, memory latency and resets
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            if (bus.i_valid && (e_iok || $urandom_range(0, 29) == 0)) bus.i_valid = 0;
            if (!bus.i_valid && $urandom_range(0, 2) == 0) begin
                bus.i_valid = 1;
                bus.i_addr  = {$urandom, $urandom} & ~64'h3;
            end
            if (bus.d_valid && (e_dok || $urandom_range(0, 29) == 0)) bus.d_valid = 0;
            if (!bus.d_valid && $urandom_range(0, 1) == 0) begin
                bus.d_valid  = 1;
                bus.d_addr   = {$urandom, $urandom};
                bus.d_size   = 3'($urandom_range(0, 3));
                bus.d_strobe = 8'($urandom);
                bus.d_wdata  = {$urandom, $urandom};
            end
            bus.m_data_ok = (md_own != 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 7) == 0);
            bus.m_rdata = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
